// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, ALU op encodings, forwarding selects
// and the bubble control word that the ID/EX stage loads when it squashes.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [OP_W-1:0] ALU_MUL = 3'd2;
  localparam logic [OP_W-1:0] ALU_AND = 3'd3;
  localparam logic [OP_W-1:0] ALU_OR  = 3'd4;

  // Operand source selects produced by forward_unit.
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            alusrc;
    logic [OP_W-1:0] aluctrl;
  } ctrl_t;

  // A bubble has no side effects: no write-back, no memory access, ADD op.
  localparam ctrl_t BUBBLE_CTRL = '{
    regwrite: 1'b0,
    memread:  1'b0,
    memwrite: 1'b0,
    memtoreg: 1'b0,
    alusrc:   1'b0,
    aluctrl:  ALU_ADD
  };

endpackage

// File: rtl/forward_unit.sv
// RAW hazard resolver: picks the newest in-flight producer of rs and rt.
// EX/MEM outranks MEM/WB because it holds the younger result; $0 never forwards.
module forward_unit #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);
  import cpu_pkg::*;

  logic exmem_live;
  logic memwb_live;

  assign exmem_live = exmem_regwrite && (exmem_rd != '0);
  assign memwb_live = memwb_regwrite && (memwb_rd != '0);

  always_comb begin
    fwd_a = FWD_REG;
    if (exmem_live && (exmem_rd == rs)) begin
      fwd_a = FWD_EXMEM;
    end else if (memwb_live && (memwb_rd == rs)) begin
      fwd_a = FWD_MEMWB;
    end
  end

  always_comb begin
    fwd_b = FWD_REG;
    if (exmem_live && (exmem_rd == rt)) begin
      fwd_b = FWD_EXMEM;
    end else if (memwb_live && (memwb_rd == rt)) begin
      fwd_b = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_forward.sv
// ID/EX pipeline register with load-use stall detection and ALU operand forwarding.
// Define FORWARD_EN to build with forward_unit; otherwise operands come from latched values only.
module id_ex_forward #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_alusrc_i,
  input  logic [OP_W-1:0]   id_aluctrl_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              id_memwrite_i,
  input  logic              id_memtoreg_i,
  input  logic              exmem_regwrite_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_data_i,
  input  logic              memwb_regwrite_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic [DATA_W-1:0] ex_data0_o,
  output logic [DATA_W-1:0] ex_data1_o,
  output logic [DATA_W-1:0] ex_store_data_o,
  output logic [OP_W-1:0]   ex_aluctrl_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              ex_regwrite_o,
  output logic              ex_memread_o,
  output logic              ex_memwrite_o,
  output logic              ex_memtoreg_o,
  output logic              stall_o
);
  import cpu_pkg::*;

  ctrl_t             ctrl_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;

  logic              load_bubble;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;

  // A load in EX whose result is needed by the instruction in ID cannot be forwarded in time.
  assign stall_o = id_valid_i && ctrl_q.memread && (rd_q != '0) &&
                   ((rd_q == id_rs_i) || (rd_q == id_rt_i));

  assign load_bubble = flush_i || stall_o || !id_valid_i;

  // Bubble clears the source tags too, so a squashed slot can never match a forward.
  always_ff @(posedge clk_i) begin
    if (!rst_i || load_bubble) begin
      ctrl_q    <= BUBBLE_CTRL;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else begin
      ctrl_q.regwrite <= id_regwrite_i;
      ctrl_q.memread  <= id_memread_i;
      ctrl_q.memwrite <= id_memwrite_i;
      ctrl_q.memtoreg <= id_memtoreg_i;
      ctrl_q.alusrc   <= id_alusrc_i;
      ctrl_q.aluctrl  <= id_aluctrl_i;
      rs_q            <= id_rs_i;
      rt_q            <= id_rt_i;
      rd_q            <= id_rd_i;
      rs_data_q       <= id_rs_data_i;
      rt_data_q       <= id_rt_data_i;
      imm_q           <= id_imm_i;
    end
  end

`ifdef FORWARD_EN
  forward_unit #(
    .REG_AW(REG_AW)
  ) u_forward_unit (
    .rs             (rs_q),
    .rt             (rt_q),
    .exmem_regwrite (exmem_regwrite_i),
    .exmem_rd       (exmem_rd_i),
    .memwb_regwrite (memwb_regwrite_i),
    .memwb_rd       (memwb_rd_i),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b)
  );
`else
  logic unused_fwd_inputs;

  assign fwd_a = FWD_REG;
  assign fwd_b = FWD_REG;
  assign unused_fwd_inputs = ^{exmem_regwrite_i, exmem_rd_i, exmem_data_i,
                               memwb_regwrite_i, memwb_rd_i, memwb_data_i, rs_q, rt_q};
`endif

  always_comb begin
    rs_fwd = rs_data_q;
    case (fwd_a)
      FWD_EXMEM: rs_fwd = exmem_data_i;
      FWD_MEMWB: rs_fwd = memwb_data_i;
      default:   rs_fwd = rs_data_q;
    endcase
  end

  always_comb begin
    rt_fwd = rt_data_q;
    case (fwd_b)
      FWD_EXMEM: rt_fwd = exmem_data_i;
      FWD_MEMWB: rt_fwd = memwb_data_i;
      default:   rt_fwd = rt_data_q;
    endcase
  end

  // The immediate overrides operand 1 outright; stores still need the forwarded rt.
  assign ex_data0_o      = rs_fwd;
  assign ex_data1_o      = ctrl_q.alusrc ? imm_q : rt_fwd;
  assign ex_store_data_o = rt_fwd;

  assign ex_aluctrl_o  = ctrl_q.aluctrl;
  assign ex_rd_o       = rd_q;
  assign ex_regwrite_o = ctrl_q.regwrite;
  assign ex_memread_o  = ctrl_q.memread;
  assign ex_memwrite_o = ctrl_q.memwrite;
  assign ex_memtoreg_o = ctrl_q.memtoreg;

endmodule

// File: tb/tb_id_ex_forward.sv
// Directed bench for id_ex_forward; expectations follow FORWARD_EN when the bench is built with it.
module tb_id_ex_forward;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        id_valid_i;
  logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
  logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
  logic        id_alusrc_i;
  logic [2:0]  id_aluctrl_i;
  logic        id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i;
  logic        exmem_regwrite_i;
  logic [4:0]  exmem_rd_i;
  logic [31:0] exmem_data_i;
  logic        memwb_regwrite_i;
  logic [4:0]  memwb_rd_i;
  logic [31:0] memwb_data_i;
  logic [31:0] ex_data0_o, ex_data1_o, ex_store_data_o;
  logic [2:0]  ex_aluctrl_o;
  logic [4:0]  ex_rd_o;
  logic        ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o;
  logic        stall_o;

  int total = 0;
  int bad   = 0;

  id_ex_forward dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
    .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .id_alusrc_i(id_alusrc_i), .id_aluctrl_i(id_aluctrl_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .id_memwrite_i(id_memwrite_i), .id_memtoreg_i(id_memtoreg_i),
    .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
    .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .ex_data0_o(ex_data0_o), .ex_data1_o(ex_data1_o), .ex_store_data_o(ex_store_data_o),
    .ex_aluctrl_o(ex_aluctrl_o), .ex_rd_o(ex_rd_o),
    .ex_regwrite_o(ex_regwrite_o), .ex_memread_o(ex_memread_o),
    .ex_memwrite_o(ex_memwrite_o), .ex_memtoreg_o(ex_memtoreg_o),
    .stall_o(stall_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  // Driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_fwd();
    exmem_regwrite_i = 1'b0; exmem_rd_i = '0; exmem_data_i = '0;
    memwb_regwrite_i = 1'b0; memwb_rd_i = '0; memwb_data_i = '0;
  endtask

  task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rs_d, input logic [31:0] rt_d, input logic [31:0] imm,
                          input logic alusrc, input logic [2:0] op,
                          input logic rw, input logic mr, input logic mw, input logic m2r);
    id_valid_i = 1'b1;
    id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
    id_rs_data_i = rs_d; id_rt_data_i = rt_d; id_imm_i = imm;
    id_alusrc_i = alusrc; id_aluctrl_i = op;
    id_regwrite_i = rw; id_memread_i = mr; id_memwrite_i = mw; id_memtoreg_i = m2r;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; flush_i = 1'b0;
    clear_fwd();
    drive_id(5'd1, 5'd2, 5'd3, 32'hAAAA, 32'hBBBB, 32'hCCCC, 1'b0, OP_SUB, 1'b1, 1'b1, 1'b1, 1'b1);
    step(); step();
    total++; if (ex_regwrite_o !== 1'b0) begin bad++; $display("FAIL rst_regwrite got=%b exp=0", ex_regwrite_o); end
    total++; if (ex_memread_o !== 1'b0) begin bad++; $display("FAIL rst_memread got=%b exp=0", ex_memread_o); end
    total++; if (ex_memwrite_o !== 1'b0) begin bad++; $display("FAIL rst_memwrite got=%b exp=0", ex_memwrite_o); end
    total++; if (ex_memtoreg_o !== 1'b0) begin bad++; $display("FAIL rst_memtoreg got=%b exp=0", ex_memtoreg_o); end
    total++; if (ex_aluctrl_o !== OP_ADD) begin bad++; $display("FAIL rst_aluctrl got=%0d exp=%0d", ex_aluctrl_o, OP_ADD); end
    total++; if (ex_rd_o !== 5'd0) begin bad++; $display("FAIL rst_rd got=%0d exp=0", ex_rd_o); end
    total++; if (ex_data0_o !== 32'h0) begin bad++; $display("FAIL rst_data0 got=%h exp=0", ex_data0_o); end
    total++; if (ex_data1_o !== 32'h0) begin bad++; $display("FAIL rst_data1 got=%h exp=0", ex_data1_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall_o); end
    // First instruction after reset: ADD r3 = r1 + r2 with 5 and 7.
    rst_i = 1'b1;
    drive_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 1'b0, OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    total++; if (ex_data0_o !== 32'd5) begin bad++; $display("FAIL add_data0 got=%h exp=%h", ex_data0_o, 32'd5); end
    total++; if (ex_data1_o !== 32'd7) begin bad++; $display("FAIL add_data1 got=%h exp=%h", ex_data1_o, 32'd7); end
    total++; if (ex_rd_o !== 5'd3) begin bad++; $display("FAIL add_rd got=%0d exp=3", ex_rd_o); end
    total++; if (ex_regwrite_o !== 1'b1) begin bad++; $display("FAIL add_regwrite got=%b exp=1", ex_regwrite_o); end
  endtask

  task automatic test_exmem_fwd();
    drive_id(5'd1, 5'd2, 5'd5, 32'h11, 32'h22, 32'h0, 1'b0, OP_SUB, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    id_valid_i = 1'b0;
    exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd1; exmem_data_i = 32'h64;
    settle();
    total++; if (ex_data0_o !== (FWD ? 32'h64 : 32'h11)) begin bad++; $display("FAIL exmem_rs got=%h exp=%h", ex_data0_o, FWD ? 32'h64 : 32'h11); end
    total++; if (ex_aluctrl_o !== OP_SUB) begin bad++; $display("FAIL exmem_aluctrl got=%0d exp=%0d", ex_aluctrl_o, OP_SUB); end
    memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd1; memwb_data_i = 32'h99;
    settle();
    total++; if (ex_data0_o !== (FWD ? 32'h64 : 32'h11)) begin bad++; $display("FAIL exmem_priority got=%h exp=%h", ex_data0_o, FWD ? 32'h64 : 32'h11); end
    exmem_regwrite_i = 1'b0;
    settle();
    total++; if (ex_data0_o !== (FWD ? 32'h99 : 32'h11)) begin bad++; $display("FAIL memwb_rs got=%h exp=%h", ex_data0_o, FWD ? 32'h99 : 32'h11); end
    clear_fwd();
    memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd2; memwb_data_i = 32'h55;
    settle();
    total++; if (ex_data1_o !== (FWD ? 32'h55 : 32'h22)) begin bad++; $display("FAIL memwb_rt got=%h exp=%h", ex_data1_o, FWD ? 32'h55 : 32'h22); end
    total++; if (ex_store_data_o !== (FWD ? 32'h55 : 32'h22)) begin bad++; $display("FAIL memwb_store got=%h exp=%h", ex_store_data_o, FWD ? 32'h55 : 32'h22); end
    clear_fwd();
    exmem_regwrite_i = 1'b0; exmem_rd_i = 5'd2; exmem_data_i = 32'h77;
    settle();
    total++; if (ex_data1_o !== 32'h22) begin bad++; $display("FAIL exmem_nowrite got=%h exp=%h", ex_data1_o, 32'h22); end
    clear_fwd();
  endtask

  task automatic test_zero_guard();
    drive_id(5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0, 1'b0, OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    id_valid_i = 1'b0;
    exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd0; exmem_data_i = 32'hFF;
    settle();
    total++; if (ex_data0_o !== 32'h0) begin bad++; $display("FAIL zero_exmem_rs got=%h exp=0", ex_data0_o); end
    exmem_regwrite_i = 1'b0;
    memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd0; memwb_data_i = 32'hAB;
    settle();
    total++; if (ex_data1_o !== 32'h0) begin bad++; $display("FAIL zero_memwb_rt got=%h exp=0", ex_data1_o); end
    clear_fwd();
  endtask

  task automatic test_load_use();
    // lw r4, 8(r1)
    drive_id(5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 32'h8, 1'b1, OP_ADD, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    total++; if (ex_memread_o !== 1'b1 || ex_rd_o !== 5'd4) begin bad++; $display("FAIL lw_in_ex got=%b/%0d exp=1/4", ex_memread_o, ex_rd_o); end
    // add r5 = r4 + r2 depends on the load
    drive_id(5'd4, 5'd2, 5'd5, 32'hDEAD, 32'h2, 32'h0, 1'b0, OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL lu_stall_rs got=%b exp=1", stall_o); end
    id_rs_i = 5'd1; id_rt_i = 5'd4;
    settle();
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL lu_stall_rt got=%b exp=1", stall_o); end
    id_valid_i = 1'b0;
    settle();
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL lu_stall_novalid got=%b exp=0", stall_o); end
    id_valid_i = 1'b1; id_rs_i = 5'd4; id_rt_i = 5'd2;
    step();
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL lu_stall_one_cycle got=%b exp=0", stall_o); end
    total++; if (ex_regwrite_o !== 1'b0 || ex_memread_o !== 1'b0) begin bad++; $display("FAIL lu_bubble_ctrl got=%b%b exp=00", ex_regwrite_o, ex_memread_o); end
    total++; if (ex_aluctrl_o !== OP_ADD || ex_rd_o !== 5'd0) begin bad++; $display("FAIL lu_bubble_op got=%0d/%0d exp=%0d/0", ex_aluctrl_o, ex_rd_o, OP_ADD); end
    // Load now in MEM; the held add enters EX and the load reaches WB.
    step();
    memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd4; memwb_data_i = 32'h1234;
    settle();
    total++; if (ex_data0_o !== (FWD ? 32'h1234 : 32'hDEAD)) begin bad++; $display("FAIL lu_memwb_fwd got=%h exp=%h", ex_data0_o, FWD ? 32'h1234 : 32'hDEAD); end
    total++; if (ex_rd_o !== 5'd5 || ex_data1_o !== 32'h2) begin bad++; $display("FAIL lu_add_in_ex got=%0d/%h exp=5/2", ex_rd_o, ex_data1_o); end
    clear_fwd();
  endtask

  task automatic test_flush();
    // lw r6, then a store that uses r6 -> stall while flush also arrives
    drive_id(5'd1, 5'd0, 5'd6, 32'h200, 32'h0, 32'h4, 1'b1, OP_ADD, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    drive_id(5'd6, 5'd3, 5'd0, 32'h0, 32'h33, 32'h0, 1'b1, OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL fl_stall got=%b exp=1", stall_o); end
    flush_i = 1'b1;
    step();
    total++; if (ex_memwrite_o !== 1'b0 || ex_regwrite_o !== 1'b0 || ex_rd_o !== 5'd0) begin bad++; $display("FAIL fl_stall_bubble got=%b%b/%0d exp=00/0", ex_memwrite_o, ex_regwrite_o, ex_rd_o); end
    // Flush alone with a store in ID still yields no store.
    step();
    flush_i = 1'b0;
    total++; if (ex_memwrite_o !== 1'b0) begin bad++; $display("FAIL fl_store_squash got=%b exp=0", ex_memwrite_o); end
    // Immediate overrides an rt forward hit; the store path still forwards rt.
    drive_id(5'd0, 5'd7, 5'd9, 32'h0, 32'h70, 32'hFFFF_FFFC, 1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    id_valid_i = 1'b0;
    exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd7; exmem_data_i = 32'h777;
    settle();
    total++; if (ex_data1_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL imm_over_fwd got=%h exp=%h", ex_data1_o, 32'hFFFF_FFFC); end
    total++; if (ex_store_data_o !== (FWD ? 32'h777 : 32'h70)) begin bad++; $display("FAIL imm_store_fwd got=%h exp=%h", ex_store_data_o, FWD ? 32'h777 : 32'h70); end
    clear_fwd();
  endtask

  task automatic test_back_to_back();
    drive_id(5'd1, 5'd2, 5'd8, 32'hF0, 32'h0F, 32'h0, 1'b0, OP_OR, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    total++; if (ex_aluctrl_o !== OP_OR || ex_rd_o !== 5'd8) begin bad++; $display("FAIL b2b_or got=%0d/%0d exp=%0d/8", ex_aluctrl_o, ex_rd_o, OP_OR); end
    drive_id(5'd3, 5'd4, 5'd9, 32'h3C, 32'hC3, 32'h0, 1'b0, OP_AND, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    total++; if (ex_aluctrl_o !== OP_AND || ex_rd_o !== 5'd9 || ex_data0_o !== 32'h3C) begin bad++; $display("FAIL b2b_and got=%0d/%0d/%h exp=%0d/9/3c", ex_aluctrl_o, ex_rd_o, ex_data0_o, OP_AND); end
    drive_id(5'd1, 5'd2, 5'd0, 32'h10, 32'h20, 32'h0, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    total++; if (ex_memwrite_o !== 1'b1 || ex_regwrite_o !== 1'b0) begin bad++; $display("FAIL b2b_store got=%b%b exp=10", ex_memwrite_o, ex_regwrite_o); end
    id_valid_i = 1'b0;
    step();
    total++; if (ex_memwrite_o !== 1'b0 || ex_rd_o !== 5'd0 || ex_data0_o !== 32'h0) begin bad++; $display("FAIL b2b_invalid got=%b/%0d/%h exp=0/0/0", ex_memwrite_o, ex_rd_o, ex_data0_o); end
    // A load targeting $0 never stalls.
    drive_id(5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, OP_ADD, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    drive_id(5'd0, 5'd0, 5'd2, 32'h0, 32'h0, 32'h0, 1'b0, OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL b2b_lw_r0_stall got=%b exp=0", stall_o); end
    id_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_exmem_fwd();
    test_zero_guard();
    test_load_use();
    test_flush();
    test_back_to_back();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
